// File: rtl/factorial_engine_if.sv
// Go/done handshake and result bundle for factorial_engine.
// The master drives the request; the slave (the engine) returns status and result.
interface factorial_engine_if #(
   parameter int unsigned SIZE = 8
);
   logic            go;
   logic            mode;
   logic [SIZE-1:0] n;
   logic [2:0]      curr_state;
   logic            busy;
   logic            done;
   logic            overflow;
   logic [SIZE-1:0] result;

   modport master (
      output go, mode, n,
      input  curr_state, busy, done, overflow, result
   );

   modport slave (
      input  go, mode, n,
      output curr_state, busy, done, overflow, result
   );
endinterface

// File: rtl/factorial_engine.sv
// Iterative n! / n!! engine behind a level go/done handshake.
// One multiply per CALC cycle, result modulo 2^SIZE, with a sticky overflow flag.
module factorial_engine #(
   parameter int unsigned SIZE = 8
) (
   input logic                clk,
   input logic                rst,
   factorial_engine_if.slave  bus
);

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StCalc = 3'd1,
      StDone = 3'd2
   } state_e;

   state_e            state_q;
   logic [SIZE-1:0]   cnt_q;
   logic [SIZE-1:0]   acc_q;
   logic [SIZE-1:0]   result_q;
   logic              step2_q;
   logic              overflow_q;

   logic [2*SIZE-1:0] prod;
   logic [SIZE-1:0]   step;
   logic              cnt_le1;

   assign prod    = {{SIZE{1'b0}}, acc_q} * {{SIZE{1'b0}}, cnt_q};
   assign step    = step2_q ? SIZE'(2) : SIZE'(1);
   assign cnt_le1 = (cnt_q[SIZE-1:1] == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         acc_q      <= '0;
         result_q   <= '0;
         step2_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (bus.go) begin
                  cnt_q      <= bus.n;
                  step2_q    <= bus.mode;
                  acc_q      <= SIZE'(1);
                  overflow_q <= 1'b0;
                  state_q    <= StCalc;
               end
            end
            StCalc: begin
               if (cnt_le1) begin
                  result_q <= acc_q;
                  state_q  <= StDone;
               end else begin
                  // cnt >= 2 here, so the subtraction never wraps
                  acc_q      <= prod[SIZE-1:0];
                  overflow_q <= overflow_q | (prod[2*SIZE-1:SIZE] != '0);
                  cnt_q      <= cnt_q - step;
               end
            end
            StDone: begin
               if (!bus.go) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.curr_state = state_q;
   assign bus.busy       = (state_q == StCalc);
   assign bus.done       = (state_q == StDone);
   assign bus.overflow   = overflow_q;
   assign bus.result     = result_q;

endmodule

// File: tb/tb_factorial_engine.sv
// Randomised bench for factorial_engine at SIZE=8 and SIZE=16 against an
// arithmetic reference model of n! and n!!.
module tb_factorial_engine;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   factorial_engine_if #(.SIZE(8))  if8  ();
   factorial_engine_if #(.SIZE(16)) if16 ();

   factorial_engine #(.SIZE(8)) u_dut8 (
      .clk (clk),
      .rst (rst),
      .bus (if8)
   );

   factorial_engine #(.SIZE(16)) u_dut16 (
      .clk (clk),
      .rst (rst),
      .bus (if16)
   );

   task automatic check(input string tag, input longint obs, input longint exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Product of all terms >= 2 in the sequence n, n-s, n-2s, ... (taken in ascending order)
   task automatic model(input int size, input int n, input bit mode,
                        output longint res, output bit ov, output int mults);
      longint lim = longint'(1) << size;
      longint modv = 1;
      longint tru = 1;
      int     k0 = mode ? ((n % 2 == 0) ? 2 : 3) : 2;
      ov = 1'b0;
      mults = 0;
      for (int k = k0; k <= n; k += (mode ? 2 : 1)) begin
         mults++;
         modv = (modv * k) % lim;
         tru = tru * k;
         if (tru >= lim) begin
            ov = 1'b1;
            tru = lim;
         end
      end
      res = modv;
   endtask

   task automatic drive(input bit wide, input bit g, input int n, input bit m);
      if (wide) begin
         if16.go = g; if16.n = 16'(n); if16.mode = m;
      end else begin
         if8.go = g; if8.n = 8'(n); if8.mode = m;
      end
   endtask

   task automatic sample(input bit wide, output int st, output bit bz, output bit dn,
                         output bit ov, output longint res);
      if (wide) begin
         st = int'(if16.curr_state); bz = if16.busy; dn = if16.done;
         ov = if16.overflow; res = longint'(if16.result);
      end else begin
         st = int'(if8.curr_state); bz = if8.busy; dn = if8.done;
         ov = if8.overflow; res = longint'(if8.result);
      end
   endtask

   task automatic run_op(input bit wide, input int n, input bit mode, input int hold);
      longint exp_res, res;
      bit     exp_ov, bz, dn, ov;
      int     mults, st, edges;
      model(wide ? 16 : 8, n, mode, exp_res, exp_ov, mults);
      @(negedge clk);
      drive(wide, 1'b1, n, mode);
      @(posedge clk); #1;
      sample(wide, st, bz, dn, ov, res);
      check("busy_after_capture", bz, 1);
      check("state_calc", st, 1);
      // inputs must be ignored during CALC
      drive(wide, 1'b1, int'($urandom), bit'($urandom_range(0, 1)));
      edges = 0;
      while (edges < mults + 20) begin
         @(posedge clk); #1;
         edges++;
         sample(wide, st, bz, dn, ov, res);
         if (dn) break;
         check("busy_in_calc", bz, 1);
      end
      check("latency", edges, mults + 1);
      check("result", res, exp_res);
      check("overflow", ov, exp_ov);
      check("state_done", st, 2);
      repeat (hold) begin
         @(posedge clk); #1;
         sample(wide, st, bz, dn, ov, res);
         check("done_hold", dn, 1);
         check("done_hold_result", res, exp_res);
      end
      @(negedge clk);
      drive(wide, 1'b0, 0, 1'b0);
      @(posedge clk); #1;
      sample(wide, st, bz, dn, ov, res);
      check("idle_return", st, 0);
      check("idle_done_low", dn, 0);
      check("idle_result_held", res, exp_res);
      check("idle_overflow_held", ov, exp_ov);
   endtask

   initial begin : main
      int     st;
      bit     bz, dn, ov;
      longint res;

      drive(1'b0, 1'b0, 0, 1'b0);
      drive(1'b1, 1'b0, 0, 1'b0);
      #2 rst = 1'b1;
      #4;
      for (int w = 0; w < 2; w++) begin
         sample(bit'(w), st, bz, dn, ov, res);
         check("reset_state", st, 0);
         check("reset_busy", bz, 0);
         check("reset_done", dn, 0);
         check("reset_overflow", ov, 0);
         check("reset_result", res, 0);
      end
      @(negedge clk);
      rst = 1'b0;

      run_op(1'b0, 5, 1'b0, 0);
      run_op(1'b0, 0, 1'b0, 0);
      run_op(1'b0, 1, 1'b0, 1);
      run_op(1'b0, 0, 1'b1, 0);
      run_op(1'b0, 1, 1'b1, 0);
      run_op(1'b0, 6, 1'b0, 0);
      run_op(1'b0, 4, 1'b0, 0);
      run_op(1'b0, 7, 1'b1, 0);
      run_op(1'b0, 8, 1'b1, 2);
      run_op(1'b0, 5, 1'b0, 10);

      // Abort mid-CALC with an asynchronous reset (previous result is nonzero)
      run_op(1'b0, 6, 1'b0, 0);
      @(negedge clk);
      drive(1'b0, 1'b1, 5, 1'b0);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      sample(1'b0, st, bz, dn, ov, res);
      check("abort_state", st, 0);
      check("abort_busy", bz, 0);
      check("abort_result", res, 0);
      check("abort_overflow", ov, 0);
      @(negedge clk);
      drive(1'b0, 1'b0, 0, 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;
      sample(1'b0, st, bz, dn, ov, res);
      check("post_abort_idle", st, 0);

      run_op(1'b1, 8, 1'b0, 0);
      run_op(1'b1, 9, 1'b0, 0);

      repeat (30) begin
         int n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                             : int'($urandom_range(0, 20));
         run_op(1'b0, n, bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      end
      repeat (10) begin
         run_op(1'b1, int'($urandom_range(0, 40)), bit'($urandom_range(0, 1)),
                int'($urandom_range(0, 2)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "timeout");
   end

endmodule
